shiftadd_issue_ctrl: RTL and testbench
======================================

// Module: shiftadd_issue_ctrl
// PURPOSE
//  Upstream issue/collect controller for the ODE solver's 16x16 shift-add multiplier (shiftadd).
//  Accepts signed operand pairs over a valid/ready handshake and drives the multiplier's a, b and
//  load (its active-high reset). Waits a fixed worst-case latency, then captures the 32-bit
//  product and rescales it to a saturated 16-bit fixed-point result for the solver datapath.
// PARAMETERS
//  MUL_LAT  17  WAIT-state cycles after the load edge; must be >= 17 (multiplier worst case 16 + 1)
//  FRAC     8   fractional bits of operand Q format; out_q = product >> FRAC; range 0..15
//  ROUND    1   1: round half up (add 2^(FRAC-1) before shift, only when FRAC>0); 0: truncate
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   controller can accept a pair
//  in_a       in   16  signed operand A
//  in_b       in   16  signed operand B
//  mul_a      out  16  to multiplier a; held stable from LOAD through capture
//  mul_b      out  16  to multiplier b; held stable from LOAD through capture
//  mul_load   out  1   to multiplier reset/load input; one-cycle pulse
//  mul_p      in   32  signed product from multiplier
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  out_p      out  32  captured signed product
//  out_q      out  16  rescaled, saturated signed result
//  out_sat    out  1   out_q was clamped
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, counter 0. mul_a, mul_b, out_p, out_q: 0.
//   mul_load, out_valid, out_sat, busy: 0. in_ready forced 0 while reset is low.
//  FSM: IDLE -> LOAD -> WAIT -> DONE -> IDLE. in_ready = (state==IDLE).
//  IDLE: when in_valid&&in_ready at edge E0, register the operands into mul_a/mul_b.
//   Operand 0x8000 is clamped to 0x8001 (the multiplier's magnitude path cannot hold +32768).
//   -> LOAD.
//  LOAD: mul_load=1 for exactly one cycle; multiplier samples at edge E1. Counter <= MUL_LAT-1.
//   -> WAIT.
//  WAIT: decrement each edge. At the edge where counter==0 (E1+MUL_LAT):
//   capture out_p<=mul_p and compute out_q/out_sat; out_valid<=1; -> DONE.
//  DONE: hold all outputs stable until out_valid&&out_ready. On that edge: out_valid<=0; -> IDLE.
//   No new accept in the same cycle.
//  Latency: accept edge to out_valid high = MUL_LAT+1 edges (18 at default).
//   Peak throughput: one result per MUL_LAT+3 cycles.
//  mul_a/mul_b must not change between E0 and capture; the multiplier reads live sign bits.
//  Rescale: t = sext33(out_p) + (ROUND && FRAC>0 ? 2^(FRAC-1) : 0); s = t >>> FRAC (arithmetic).
//   If s > 32767: out_q=0x7FFF, out_sat=1. If s < -32768: out_q=0x8000, out_sat=1.
//   Otherwise out_q=s[15:0], out_sat=0.
//  in_valid while not IDLE: ignored; the source holds its data.
//   in_a/in_b changes while not IDLE have no effect.
//  Reset mid-operation: immediate return to the reset state; any in-flight product is discarded.
//   The multiplier's state is irrelevant because every issue starts with a mul_load pulse.
//  out_ready high outside DONE: no effect.
// TESTING
//  1 FRAC=0: in_a=3, in_b=-5 -> exactly one mul_load pulse; out_valid 18 edges after accept;
//    out_p=0xFFFFFFF1, out_q=0xFFF1, out_sat=0.
//  2 FRAC=8: 0x0180 (1.5) * 0xFE00 (-2.0) -> out_p=0xFFFD0000, out_q=0xFD00 (-3.0), out_sat=0.
//  3 FRAC=8: 0x7FFF*0x7FFF -> out_p=0x3FFF0001, out_q=0x7FFF, out_sat=1.
//    0x8000*0x0001 -> mul_a=0x8001, out_p=0xFFFF8001.
//  4 FRAC=8, ROUND=1: 3*128 -> out_p=384, out_q=2. Same with ROUND=0 -> out_q=1.
//  5 out_ready low 6 cycles in DONE -> out_* stable, in_ready=0, no mul_load.
//    Second pair is accepted only after the handshake; back-to-back products are correct.
//  6 reset low for 1 cycle at WAIT count 5 -> all outputs at reset values immediately; no stale out_valid;
//    the next pair produces a correct result.

Source files
------------

// File: rtl/shiftadd_issue_ctrl.sv
// Issue/collect controller for the 16x16 shift-add multiplier; result valid MUL_LAT+1 edges after accept.
// Backpressure: one pair in flight; in_ready low until the result is taken with out_valid&&out_ready.
module shiftadd_issue_ctrl #(
  parameter int MUL_LAT = 17,
  parameter int FRAC    = 8,
  parameter int ROUND   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_load,
  input  logic [31:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic [15:0] out_q,
  output logic        out_sat,
  output logic        busy
);

  localparam int CW  = $clog2(MUL_LAT + 1);
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [32:0] RND =
    (ROUND != 0 && FRAC > 0) ? (33'sd1 <<< RSH) : 33'sd0;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic signed [32:0] t_sum;
  logic signed [32:0] s_shr;
  logic [15:0]        q_nxt;
  logic               sat_nxt;

  // The multiplier's magnitude path cannot represent +32768, so -32768 is nudged to -32767.
  function automatic logic [15:0] clamp_op(input logic [15:0] v);
    return (v == 16'h8000) ? 16'h8001 : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset && (state == IDLE);
    mul_load  = (state == LOAD);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_comb begin
    t_sum   = $signed({mul_p[31], mul_p}) + RND;
    s_shr   = t_sum >>> FRAC;
    q_nxt   = s_shr[15:0];
    sat_nxt = 1'b0;
    if (s_shr > 33'sd32767) begin
      q_nxt   = 16'h7FFF;
      sat_nxt = 1'b1;
    end else if (s_shr < -33'sd32768) begin
      q_nxt   = 16'h8000;
      sat_nxt = 1'b1;
    end
  end

  // Operands stay frozen from accept through capture: the multiplier reads live sign bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      out_p   <= '0;
      out_q   <= '0;
      out_sat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mul_a <= clamp_op(in_a);
          mul_b <= clamp_op(in_b);
        end
        LOAD: cnt <= CW'(MUL_LAT - 1);
        WAIT: if (cnt == '0) begin
          out_p   <= mul_p;
          out_q   <= q_nxt;
          out_sat <= sat_nxt;
        end else begin
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftadd_issue_ctrl.sv
// Three controllers (FRAC8/round, FRAC0, FRAC8/truncate) in lockstep on a behavioural shift-add multiplier.
module tb_shiftadd_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_a, in_b;
  logic        out_ready;
  logic [31:0] mul_p = '0;
  int          mcnt = 0;

  logic        rdy [3];
  logic [15:0] ma  [3];
  logic [15:0] mb  [3];
  logic        ld  [3];
  logic        ov  [3];
  logic [31:0] op  [3];
  logic [15:0] oq  [3];
  logic        os  [3];
  logic        bz  [3];

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    logic [15:0] ca;
    logic [15:0] cb;
    logic [31:0] p;
    logic [15:0] q   [3];
    logic        sat [3];
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    shiftadd_issue_ctrl #(
      .MUL_LAT(17),
      .FRAC   ((g == 1) ? 0 : 8),
      .ROUND  ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .in_valid (in_valid),
      .in_ready (rdy[g]),
      .in_a     (in_a),
      .in_b     (in_b),
      .mul_a    (ma[g]),
      .mul_b    (mb[g]),
      .mul_load (ld[g]),
      .mul_p    (mul_p),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_p    (op[g]),
      .out_q    (oq[g]),
      .out_sat  (os[g]),
      .busy     (bz[g])
    );
  end

  // Multiplier: garbage until 16 edges after the load edge, product of the live operands after that.
  always @(posedge clk) begin
    if (ld[0]) begin
      mcnt  <= 16;
      mul_p <= 32'hDEADBEEF;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_p <= 32'(int'($signed(ma[0])) * int'($signed(mb[0])));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] rescale(input logic [31:0] p, input int frac, input int rnd);
    longint t;
    t = longint'($signed(p));
    if (rnd != 0 && frac > 0) t = t + (longint'(1) << (frac - 1));
    t = t >>> frac;
    if (t > 32767)  return {1'b1, 16'h7FFF};
    if (t < -32768) return {1'b1, 16'h8000};
    return {1'b0, t[15:0]};
  endfunction

  function automatic exp_t mk_exp(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] r;
    e.ca = (a == 16'h8000) ? 16'h8001 : a;
    e.cb = (b == 16'h8000) ? 16'h8001 : b;
    e.p  = 32'(int'($signed(e.ca)) * int'($signed(e.cb)));
    for (int i = 0; i < 3; i++) begin
      r = rescale(e.p, (i == 1) ? 0 : 8, (i == 2) ? 0 : 1);
      e.q[i]   = r[15:0];
      e.sat[i] = r[16];
    end
    return e;
  endfunction

  task automatic chk_out(input string tag, input exp_t g);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(ov[i]), 32'd1);
      chk($sformatf("%s_p%0d", tag, i), op[i], g.p);
      chk($sformatf("%s_q%0d", tag, i), 32'(oq[i]), 32'(g.q[i]));
      chk($sformatf("%s_sat%0d", tag, i), 32'(os[i]), 32'(g.sat[i]));
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    exp_t e, g;
    int w, lat, loads;
    logic moved;
    out_ready = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    w = 0;
    while (rdy[0] !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) begin
      chk("accept_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e = mk_exp(a, b);
    sb.push_back(e);
    chk("mul_a", 32'(ma[0]), 32'(e.ca));
    chk("mul_b", 32'(mb[0]), 32'(e.cb));
    in_a = ~a; in_b = b ^ 16'h5A5A;
    lat = 0; loads = 0; moved = 1'b0;
    while (ov[0] !== 1'b1 && lat < 60) begin
      if (ld[0] === 1'b1) loads++;
      if (ma[0] !== e.ca || mb[0] !== e.cb) moved = 1'b1;
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'd18);
    chk("load_pulses", 32'(loads), 32'd1);
    chk("operands_held", 32'(moved), 32'd0);
    if (ov[0] !== 1'b1) return;
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    g = sb.pop_front();
    chk_out("res", g);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk_out("hold", g);
      chk("hold_in_ready", 32'(rdy[0]), 32'd0);
      chk("hold_load", 32'(ld[0]), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid0", 32'(ov[0]), 32'd0);
    chk("post_valid1", 32'(ov[1]), 32'd0);
    chk("post_in_ready", 32'(rdy[0]), 32'd1);
  endtask

  initial begin
    logic stray;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(rdy[0]), 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_load", 32'(ld[0]), 32'd0);
    chk("rst_mul_a", 32'(ma[0]), 32'd0);
    chk("rst_out_p", op[0], 32'd0);
    chk("rst_out_q", 32'(oq[0]), 32'd0);
    chk("rst_sat", 32'(os[0]), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 32'(rdy[0]), 32'd1);
    chk("idle_busy", 32'(bz[0]), 32'd0);

    do_op(16'd3, 16'hFFFB, 0);
    do_op(16'h0180, 16'hFE00, 0);
    do_op(16'h7FFF, 16'h7FFF, 0);
    do_op(16'h8000, 16'h0001, 0);
    do_op(16'd3, 16'd128, 0);
    do_op(16'h1234, 16'hA5A5, 6);
    do_op(16'h0100, 16'h0100, 0);

    // Reset pulse while WAIT counter is at 5.
    in_a = 16'h0200; in_b = 16'h0300; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bz[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_busy", 32'(bz[0]), 32'd0);
    chk("mid_rst_in_ready", 32'(rdy[0]), 32'd0);
    chk("mid_rst_out_p", op[0], 32'd0);
    chk("mid_rst_out_q", 32'(oq[0]), 32'd0);
    chk("mid_rst_mul_a", 32'(ma[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    stray = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0 || bz[0] !== 1'b0) stray = 1'b1;
    end
    chk("no_stale_valid", 32'(stray), 32'd0);
    do_op(16'hFF80, 16'h0280, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
